deser_queue_top: RTL and testbench

- Top-level serial-to-parallel receiver with FIFO buffering. A 1 MHz system clock drives everything.
- A serial deserializer assembles 8-bit words, MSB first, from strobed bits and pushes each finished word into an 8-deep FIFO.
- Words leave the FIFO on a dequeue request and appear on data_out.
- Internally there are two clock-enable domains, both derived from the one clock: a 100 kHz deserializer tick and a 10 kHz queue tick.

---
 rtl/deser_queue_pkg.sv | 25 ++
 rtl/word_fifo.sv | 68 ++++++
 rtl/deser_queue_top.sv | 132 +++++++++++++
 tb/tb_deser_queue_top.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/deser_queue_pkg.sv
// Shared constants, word type and deserializer state encoding for the serial receive queue.
package deser_queue_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned DESER_DIV = 10;
    localparam int unsigned QUEUE_DIV = 100;

    localparam int unsigned PTR_W       = $clog2(DEPTH);
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1);
    localparam int unsigned BIT_CNT_W   = $clog2(WORD_W);
    localparam int unsigned DESER_CNT_W = $clog2(DESER_DIV);
    localparam int unsigned QUEUE_CNT_W = $clog2(QUEUE_DIV);

    typedef logic [WORD_W-1:0] word_t;

    // StInit: first tick after reset; StIdle/StRecv: accepting bits; StFullWait: word pending
    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StRecv,
        StFullWait
    } deser_state_e;

endpackage

// File: rtl/word_fifo.sv
// Circular word buffer; a push while full is accepted only when a pop frees the slot.
module word_fifo
    import deser_queue_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    word_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy next-state with modulo-DEPTH wrap
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; when full with a pop, the head is read before this write lands
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/deser_queue_top.sv
// Serial-to-parallel receiver: MSB-first deserializer on a 100 kHz enable feeding an 8-deep
// FIFO serviced on a 10 kHz enable, both derived from the 1 MHz clock.
module deser_queue_top
    import deser_queue_pkg::*;
(
    input  logic              clock_1MHz,
    input  logic              rst,
    input  logic              data_in,
    input  logic              write_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    output logic              status_out,
    output logic [WORD_W-1:0] data_out
);

    logic [DESER_CNT_W-1:0] deser_cnt_q;
    logic [QUEUE_CNT_W-1:0] queue_cnt_q;
    logic                   deser_tick, queue_tick;

    deser_state_e           state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    word_t                  shift_q, pending_q, shift_next;
    logic                   valid_pending_q, status_q, wr_prev_q, wr_rise;

    logic                   deq_prev_q;
    word_t                  data_q, fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   pop_ok, push_ok;
    logic                   unused_enqueue;

    // Enqueue is reserved: pushes are driven solely by completed words
    assign unused_enqueue = enqueue_in;

    assign deser_tick = (deser_cnt_q == DESER_CNT_W'(DESER_DIV - 1));
    assign queue_tick = (queue_cnt_q == QUEUE_CNT_W'(QUEUE_DIV - 1));

    assign wr_rise    = write_in & ~wr_prev_q;
    assign shift_next = {shift_q[WORD_W-2:0], data_in};

    assign pop_ok  = queue_tick & dequeue_in & ~deq_prev_q & ~fifo_empty;
    assign push_ok = queue_tick & valid_pending_q & (~fifo_full | pop_ok);

    assign status_out = status_q;
    assign data_out   = data_q;

    // Free-running clock-enable dividers
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            deser_cnt_q <= '0;
            queue_cnt_q <= '0;
        end else begin
            deser_cnt_q <= deser_tick ? '0 : deser_cnt_q + 1'b1;
            queue_cnt_q <= queue_tick ? '0 : queue_cnt_q + 1'b1;
        end
    end

    // Deserializer FSM: edge-detect write_in per tick, assemble word, hold it until pushed
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            state_q         <= StInit;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            pending_q       <= '0;
            valid_pending_q <= 1'b0;
            status_q        <= 1'b0;
            wr_prev_q       <= 1'b0;
        end else begin
            // Clear happens on the queue side; set only occurs while already clear
            if (push_ok) begin
                valid_pending_q <= 1'b0;
            end
            if (deser_tick) begin
                wr_prev_q <= write_in;
                unique case (state_q)
                    StInit: begin
                        status_q <= 1'b1;
                        state_q  <= StIdle;
                    end
                    StIdle, StRecv: begin
                        if (wr_rise) begin
                            shift_q <= shift_next;
                            if (bit_cnt_q == BIT_CNT_W'(WORD_W - 1)) begin
                                pending_q       <= shift_next;
                                valid_pending_q <= 1'b1;
                                status_q        <= 1'b0;
                                bit_cnt_q       <= '0;
                                state_q         <= StFullWait;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                state_q   <= StRecv;
                            end
                        end
                    end
                    StFullWait: begin
                        if (!valid_pending_q) begin
                            status_q <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end
                    default: state_q <= StInit;
                endcase
            end
        end
    end

    // Dequeue edge detect and output word register
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            deq_prev_q <= 1'b0;
            data_q     <= '0;
        end else if (queue_tick) begin
            deq_prev_q <= dequeue_in;
            if (pop_ok) begin
                data_q <= fifo_rdata;
            end
        end
    end

    word_fifo u_fifo (
        .clk_i   (clock_1MHz),
        .rst_ni  (rst),
        .push_i  (push_ok),
        .wdata_i (pending_q),
        .pop_i   (pop_ok),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_deser_queue_top.sv
// Directed bench for deser_queue_top: reset, single word, fill, overflow stall, drain,
// empty pop and mid-word reset.
`timescale 1ns/1ps
module tb_deser_queue_top;

    logic       clock_1MHz = 1'b0;
    logic       rst        = 1'b0;
    logic       data_in    = 1'b0;
    logic       write_in   = 1'b0;
    logic       enqueue_in = 1'b0;
    logic       dequeue_in = 1'b0;
    logic       status_out;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_err = 0;

    deser_queue_top dut (
        .clock_1MHz (clock_1MHz),
        .rst        (rst),
        .data_in    (data_in),
        .write_in   (write_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .status_out (status_out),
        .data_out   (data_out)
    );

    always #500 clock_1MHz = ~clock_1MHz;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bit = write_in high 10 us, low 10 us; st8 is status at the end of bit 8's high phase
    task automatic send_bits(input logic [7:0] w, input int nbits, output logic st8);
        st8 = 1'bx;
        for (int i = 0; i < nbits; i++) begin
            data_in  = w[7-i];
            write_in = 1'b1;
            repeat (10) @(negedge clock_1MHz);
            if (i == 7) st8 = status_out;
            write_in = 1'b0;
            repeat (10) @(negedge clock_1MHz);
        end
    endtask

    task automatic wait_status_high(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock_1MHz);
            if (status_out === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pop_pulse();
        dequeue_in = 1'b1;
        repeat (200) @(negedge clock_1MHz);
        dequeue_in = 1'b0;
        repeat (600) @(negedge clock_1MHz);
    endtask

    initial begin
        logic st;
        logic ok;

        // Reset held 2.7 us, released between clock edges
        #1200;
        check_eq("rst_status", status_out, 0);
        check_eq("rst_data", data_out, 8'h00);
        #1500;
        rst = 1'b1;
        @(negedge clock_1MHz);
        check_eq("post_rst_data", data_out, 8'h00);
        check_eq("post_rst_status_low", status_out, 0);
        wait_status_high(12, ok);
        check_eq("status_up_10us", ok, 1);

        // Single word 0x80
        send_bits(8'h80, 8, st);
        check_eq("single_status_drop", st, 0);
        wait_status_high(110, ok);
        check_eq("single_status_back", ok, 1);
        check_eq("single_count", dut.u_fifo.count_o, 1);

        // Fill with 0x81..0x87 behind 0x80
        for (int k = 1; k < 8; k++) begin
            send_bits(8'h80 + 8'(k), 8, st);
            repeat (300) @(negedge clock_1MHz);
        end
        check_eq("fill_count", dut.u_fifo.count_o, 8);
        check_eq("fill_status", status_out, 1);

        // Ninth word stalls while full
        send_bits(8'h88, 8, st);
        check_eq("ovf_status_drop", st, 0);
        repeat (300) @(negedge clock_1MHz);
        check_eq("ovf_status_stall", status_out, 0);
        check_eq("ovf_count", dut.u_fifo.count_o, 8);
        check_eq("ovf_data_hold", data_out, 8'h00);

        // Drain four; pending 0x88 slides in on the first pop
        for (int k = 0; k < 4; k++) begin
            pop_pulse();
            check_eq("drain_data", data_out, 8'h80 + 8'(k));
            if (k == 0) begin
                check_eq("drain_status_back", status_out, 1);
                check_eq("drain_count_full", dut.u_fifo.count_o, 8);
            end
        end
        check_eq("drain4_count", dut.u_fifo.count_o, 5);

        // Drain the rest, including 0x88
        for (int k = 4; k < 9; k++) begin
            pop_pulse();
            check_eq("drain_rest_data", data_out, 8'h80 + 8'(k));
        end
        check_eq("empty_count", dut.u_fifo.count_o, 0);

        // Pop on empty holds data_out
        pop_pulse();
        check_eq("empty_pop_hold", data_out, 8'h88);
        check_eq("empty_pop_count", dut.u_fifo.count_o, 0);

        // Reset after three bits of a word
        send_bits(8'hE0, 3, st);
        #200;
        rst = 1'b0;
        #1000;
        check_eq("midrst_status", status_out, 0);
        check_eq("midrst_data", data_out, 8'h00);
        check_eq("midrst_count", dut.u_fifo.count_o, 0);
        #1500;
        rst = 1'b1;
        @(negedge clock_1MHz);
        wait_status_high(12, ok);
        check_eq("midrst_status_up", ok, 1);

        send_bits(8'h3C, 8, st);
        check_eq("after_rst_drop", st, 0);
        repeat (300) @(negedge clock_1MHz);
        check_eq("after_rst_count", dut.u_fifo.count_o, 1);
        check_eq("after_rst_status", status_out, 1);
        pop_pulse();
        check_eq("after_rst_word", data_out, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
